apple_spawn_ctrl: RTL
=====================

// Module: apple_spawn_ctrl
// PURPOSE
// - Controls apple placement for the snake game on a 32x24 cell grid with 20 px cells (640x480).
// - On each game tick, compares the snake head cell with the apple cell.
// - On a hit it increments the score and searches for a free cell: LFSR candidates first, then a linear scan.
// - Each candidate is checked against the snake-body occupancy store through a req/ack query port.
// - The apple position is committed in pixels for the VGA renderer.
// - Sits between the snake movement unit (head, tick), the body store (occupancy) and the renderer.
// PARAMETERS
// - LFSR_SEED  16'hACE1  non-zero LFSR reset value (a zero value is replaced by 16'h0001)
// - MAX_TRIES  8         random candidates tried before falling back to the linear scan, 1..15
// - INIT_X     16        apple cell x after reset, 0..31
// - INIT_Y     12        apple cell y after reset, 0..23
// PORTS
// - clk          in   1   single system clock; all logic on its rising edge
// - rst          in   1   synchronous, active-high reset
// - tick         in   1   one-cycle game-step strobe from the movement unit
// - head_x       in   5   snake head cell x, valid when tick=1
// - head_y       in   5   snake head cell y, valid when tick=1
// - occ_req      out  1   occupancy query request
// - occ_x        out  5   query cell x
// - occ_y        out  5   query cell y
// - occ_ack      in   1   query answered this cycle
// - occ_hit      in   1   queried cell holds body; sampled only when occ_ack=1
// - apple_px_x   out  10  apple x in pixels (cell*20)
// - apple_px_y   out  10  apple y in pixels (cell*20)
// - apple_valid  out  1   apple position is committed and drawable
// - score        out  8   apples eaten, saturates at 255
// - eaten        out  1   one-cycle pulse, apple consumed
// - busy         out  1   placement search in progress
// - board_full   out  1   no free cell exists; sticky until rst
// BEHAVIOUR
// - Reset values: apple cell = (INIT_X, INIT_Y), so px = (320, 240) at defaults.
//   Also: apple_valid=1, score=0, eaten=0, busy=0, occ_req=0, board_full=0, LFSR=LFSR_SEED, state IDLE.
// - States:
//   - IDLE: on tick with head==apple cell -> GEN. In the next cycle: eaten=1, score+1 (saturating), apple_valid=0.
//     On tick without a match, or no tick: stay in IDLE.
//   - GEN: LFSR steps once, taps 16,14,13,11. cand_x=lfsr[4:0]; cand_y=lfsr[9:5], minus 8 if >=24.
//     try_cnt+1, then -> QUERY.
//   - QUERY: occ_req=1 with occ_x/occ_y held stable until occ_ack.
//     On ack, deassert occ_req next cycle.
//     - Candidate free (occ_hit=0) and not equal to the last head cell -> COMMIT.
//     - Otherwise: if try_cnt<MAX_TRIES -> GEN; else -> SCAN with scan origin = current candidate.
//   - SCAN: cand = next cell in raster order; x wraps 31->0 with y+1, y wraps 23->0. Then -> QUERY (scan mode).
//     If cand returns to the scan origin (768 cells checked) -> FULL.
//   - COMMIT: one cycle. apple cell <= cand, apple_valid=1, try_cnt=0, busy=0 -> IDLE.
//   - FULL: board_full=1, apple_valid=0, occ_req=0. Terminal until rst.
// - busy=1 in every state except IDLE and FULL.
// - tick while busy or FULL is ignored: no eat check and no score change. The movement unit must not tick before busy falls.
// - Latency: tick -> eaten is 1 cycle. Best case tick -> apple_valid is 1+1+(ack delay+1)+1 cycles.
// - Pixel conversion: px = (cell<<4)+(cell<<2), 10-bit, maximum 620 / 460. No multiplier.
// - occ_ack while occ_req=0 is ignored. occ_hit is don't-care without ack.
// - rst mid-search: abandon the query immediately (occ_req=0 next cycle) and restore all reset values; score is lost.
// STRUCTURE
// - snake_pkg: GRID_W=32, GRID_H=24, CELL_PX=20, CELL_BITS=5, state encoding localparams (IDLE..FULL).
// - Sub-module lfsr16: Galois LFSR with enable and seed load, reset to a non-zero seed.
// - The FSM, candidate/scan counters and pixel conversion stay in this module.
// TESTING
// - Reset, then check outputs -> px=(320,240), apple_valid=1, score=0, busy=0, board_full=0.
// - tick with head=(16,12), occupancy model always free with 1-cycle ack.
//   -> eaten pulse 1 cycle, score=1, new apple != (16,12) within 5 cycles, busy falls.
// - tick with head=(3,3) != apple -> no eaten, score unchanged, no occ_req.
// - Model reports the first 8 candidates hit, the 9th query free.
//   -> scan mode taken, committed cell = origin+1 in raster order.
//   Origin (31,23) -> commit (0,0), px=(0,0).
// - Model reports every cell hit -> exactly 768 scan queries, then board_full=1, apple_valid=0, busy=0.
// - Score preset by 255 eats -> 256th eat keeps score=255. Assert rst while occ_req=1 -> occ_req=0 next cycle, reset values restored.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: grid geometry, apple-spawn FSM states and cell-to-pixel helper
package snake_pkg;
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int CELL_PX = 20;
  localparam int CELL_BITS = 5;
  typedef enum logic [2:0] {IDLE, GEN, QUERY, SCAN, COMMIT, FULL} state_t;
  function automatic logic [9:0] cell_px(input logic [CELL_BITS-1:0] c);
    return {1'b0, c, 4'b0} + {3'b0, c, 2'b0};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: Galois LFSR (taps 16,14,13,11) that loads its seed on reset and steps when enabled
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cand_bits
);
  localparam logic [15:0] S = (SEED == 16'h0) ? 16'h0001 : SEED;
  logic [15:0] q, nxt;
  assign nxt = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  assign cand_bits = nxt[9:0];
  always_ff @(posedge clk)
    if (rst) q <= S;
    else if (en) q <= nxt;
endmodule

// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl: eat detection, score and free-cell search (random then raster scan) for the apple
module apple_spawn_ctrl
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MAX_TRIES = 8,
  parameter int INIT_X = 16,
  parameter int INIT_Y = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] head_x,
  input  logic [4:0] head_y,
  output logic       occ_req,
  output logic [4:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [9:0] apple_px_x,
  output logic [9:0] apple_px_y,
  output logic       apple_valid,
  output logic [7:0] score,
  output logic       eaten,
  output logic       busy,
  output logic       board_full
);
  state_t state, state_n;
  logic [4:0] ax, ay, cx, cy, ox, oy, hx, hy, gx, gy, nx, ny;
  logic [3:0] tries;
  logic [9:0] rb;
  logic scan_mode, eat, rej, at_origin;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .en(state == GEN), .cand_bits(rb));
  assign eat = tick && head_x == ax && head_y == ay;
  assign gx = rb[4:0];
  assign gy = rb[9:5] >= 5'(GRID_H) ? rb[9:5] - 5'd8 : rb[9:5];
  assign nx = cx == 5'(GRID_W - 1) ? 5'd0 : cx + 5'd1;
  assign ny = cx != 5'(GRID_W - 1) ? cy : cy == 5'(GRID_H - 1) ? 5'd0 : cy + 5'd1;
  assign rej = occ_hit || (cx == hx && cy == hy);
  assign at_origin = cx == ox && cy == oy;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = eat ? GEN : IDLE;
      GEN:    state_n = QUERY;
      QUERY:  if (occ_ack)
                state_n = !rej ? COMMIT :
                          scan_mode ? (at_origin ? FULL : SCAN) :
                          tries < 4'(MAX_TRIES) ? GEN : SCAN;
      SCAN:   state_n = QUERY;
      COMMIT: state_n = IDLE;
      FULL:   state_n = FULL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ax <= 5'(INIT_X);
      ay <= 5'(INIT_Y);
      cx <= '0;
      cy <= '0;
      ox <= '0;
      oy <= '0;
      hx <= '0;
      hy <= '0;
      tries <= '0;
      scan_mode <= 1'b0;
      apple_valid <= 1'b1;
      score <= '0;
      eaten <= 1'b0;
    end else begin
      state <= state_n;
      eaten <= state == IDLE && eat;
      if (state == IDLE && eat) begin
        score <= score + {7'b0, score != 8'hFF};
        apple_valid <= 1'b0;
        hx <= head_x;
        hy <= head_y;
      end
      if (state == GEN) begin
        cx <= gx;
        cy <= gy;
        tries <= tries + 4'd1;
      end
      // the last random candidate becomes the scan origin
      if (state == QUERY && state_n == SCAN && !scan_mode) begin
        scan_mode <= 1'b1;
        ox <= cx;
        oy <= cy;
      end
      if (state == SCAN) begin
        cx <= nx;
        cy <= ny;
      end
      if (state == COMMIT) begin
        ax <= cx;
        ay <= cy;
        apple_valid <= 1'b1;
        tries <= '0;
        scan_mode <= 1'b0;
      end
    end
  end
  assign occ_req = state == QUERY;
  assign occ_x = cx;
  assign occ_y = cy;
  assign busy = state != IDLE && state != FULL;
  assign board_full = state == FULL;
  assign apple_px_x = cell_px(ax);
  assign apple_px_y = cell_px(ay);
endmodule
